draw_arbiter: RTL

Shares the single sprite drawer between several movement controllers (player character, moving platform, button animations). Each requester issues one-cycle draw requests (background redraw or sprite draw) with a screen coordinate. The arbiter latches them, grants the drawer round-robin, and returns a one-cycle `done` to the owning requester when the drawer finishes. It sits between the movement FSMs' `drawBG`/`drawChar`/`doneBG`/`doneChar` handshake and the sprite drawer FSM.

---
 rtl/draw_arbiter_pkg.sv | 22 ++
 rtl/draw_arbiter_if.sv | 30 +++
 rtl/draw_arbiter_rr_pick.sv | 29 ++
 rtl/draw_arbiter.sv | 108 ++++++++++
 4 files changed

// File: rtl/draw_arbiter_pkg.sv
// Shared encodings and widths for the sprite-drawer arbiter.
package draw_arb_pkg;

  localparam int X_W = 9;
  localparam int Y_W = 8;

  localparam logic KIND_BG   = 1'b1;
  localparam logic KIND_CHAR = 1'b0;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_ACK   = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ISSUE = ST_ISSUE,
    WAIT  = ST_WAIT,
    ACK   = ST_ACK
  } arb_state_t;

endpackage

// File: rtl/draw_arbiter_if.sv
// Requester-side and drawer-side handshake of the draw arbiter.
interface draw_arbiter_if #(
  parameter int N   = 4,
  parameter int IDW = 3
);
  import draw_arb_pkg::*;

  logic [N-1:0]     req;
  logic [N-1:0]     req_bg;
  logic [X_W*N-1:0] req_x;
  logic [Y_W*N-1:0] req_y;
  logic [N-1:0]     done;
  logic [N-1:0]     pending;
  logic             draw_start;
  logic             draw_bg;
  logic [X_W-1:0]   draw_x;
  logic [Y_W-1:0]   draw_y;
  logic [IDW-1:0]   draw_id;
  logic             draw_done;

  modport slave (
    input  req, req_bg, req_x, req_y, draw_done,
    output done, pending, draw_start, draw_bg, draw_x, draw_y, draw_id
  );

  modport master (
    output req, req_bg, req_x, req_y, draw_done,
    input  done, pending, draw_start, draw_bg, draw_x, draw_y, draw_id
  );
endinterface

// File: rtl/draw_arbiter_rr_pick.sv
// Round-robin pick: first valid slot searching upward from last+1, wrapping mod N.
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 3
) (
  input  logic [N-1:0]   valid,
  input  logic [IDW-1:0] last,
  output logic           any,
  output logic [IDW-1:0] grant
);

  int  idx;
  logic found;

  always_comb begin
    any   = |valid;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + k) % N;
      if (!found && valid[idx]) begin
        found = 1'b1;
        grant = idx[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/draw_arbiter.sv
// Latches one-cycle draw requests per requester and hands the single sprite
// drawer to them round-robin, returning a one-cycle done to the owner.
module draw_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 3
) (
  input  logic        clock,
  input  logic        reset,
  draw_arbiter_if.slave bus
);
  import draw_arb_pkg::*;

  // state | meaning
  // IDLE  | no grant outstanding; pick next valid slot
  // ISSUE | one-cycle draw_start to the drawer
  // WAIT  | drawer busy; wait for draw_done
  // ACK   | done pulse to owner; slot cleared, last updated

  arb_state_t state_q, state_d;

  logic [N-1:0]   slot_valid;
  logic [N-1:0]   slot_bg;
  logic [X_W-1:0] slot_x [N];
  logic [Y_W-1:0] slot_y [N];

  logic           pick_any;
  logic [IDW-1:0] pick_id;
  logic [IDW-1:0] grant_q;
  logic [IDW-1:0] last_q;
  logic           bg_q;
  logic [X_W-1:0] x_q;
  logic [Y_W-1:0] y_q;
  logic [N-1:0]   ack_vec;

  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .valid (slot_valid),
    .last  (last_q),
    .any   (pick_any),
    .grant (pick_id)
  );

  assign ack_vec = (state_q == ACK) ? ({{(N-1){1'b0}}, 1'b1} << grant_q) : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_any) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (bus.draw_done) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A new request on the slot being acknowledged wins over the clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot_valid <= '0;
      slot_bg    <= '0;
      for (int i = 0; i < N; i++) begin
        slot_x[i] <= '0;
        slot_y[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (bus.req[i] && (!slot_valid[i] || ack_vec[i])) begin
          slot_valid[i] <= 1'b1;
          slot_bg[i]    <= bus.req_bg[i];
          slot_x[i]     <= bus.req_x[X_W*i +: X_W];
          slot_y[i]     <= bus.req_y[Y_W*i +: Y_W];
        end else if (ack_vec[i]) begin
          slot_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grant_q <= '0;
      last_q  <= IDW'(N - 1);
      bg_q    <= KIND_CHAR;
      x_q     <= '0;
      y_q     <= '0;
    end else if (state_q == IDLE && pick_any) begin
      grant_q <= pick_id;
      bg_q    <= slot_bg[pick_id];
      x_q     <= slot_x[pick_id];
      y_q     <= slot_y[pick_id];
    end else if (state_q == ACK) begin
      last_q  <= grant_q;
    end
  end

  assign bus.done       = ack_vec;
  assign bus.pending    = slot_valid;
  assign bus.draw_start = (state_q == ISSUE);
  assign bus.draw_bg    = bg_q;
  assign bus.draw_x     = x_q;
  assign bus.draw_y     = y_q;
  assign bus.draw_id    = grant_q;

endmodule
